ps2_key_assembler: RTL

PS2_KEY_ASSEMBLER -- requirements
Module: ps2_key_assembler

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_key_assembler_if.sv | 17 +
 rtl/ps2_frame_rx.sv | 156 +++++++++++++++
 rtl/ps2_key_assembler.sv | 105 ++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key assembler.
//   frame_state_e : serial frame FSM states
//   ps2_key_t     : {toggle, 64-bit key sequence} output payload
//   PS2_PFX_*     : scan-code prefix bytes; PS2_PAUSE_LEN: pause sequence length
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0]  PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0]  PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0]  PS2_PFX_PAUSE = 8'hE1;
  localparam int unsigned PS2_PAUSE_LEN = 8;

  localparam int unsigned PS2_SEQ_W = 64;
  localparam int unsigned PS2_KEY_W = PS2_SEQ_W + 1;
  localparam int unsigned PS2_CNT_W = 4;

  typedef struct packed {
    logic                 toggle;
    logic [PS2_SEQ_W-1:0] seq;
  } ps2_key_t;

  // Prefix bytes never end a sequence on their own.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK) || (b == PS2_PFX_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_key_assembler_if.sv
// ps2_key_assembler_if: PS/2 device pins plus the decoded key outputs.
//   ps2_clk, ps2_data : raw device lines (driven by master, read by slave)
//   ps2_key           : {toggle, sequence} event register (driven by slave)
//   frame_err         : discarded-frame pulse (driven by slave)
interface ps2_key_assembler_if
  import ps2_pkg::*;
  ();

  logic                 ps2_clk;
  logic                 ps2_data;
  logic [PS2_KEY_W-1:0] ps2_key;
  logic                 frame_err;

  modport master (output ps2_clk, output ps2_data, input ps2_key, input frame_err);
  modport slave  (input ps2_clk, input ps2_data, output ps2_key, output frame_err);

endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes and filters the PS/2 lines, receives one
// 11-bit frame per byte and flags timeouts and bad frames.
//   clk_sys, reset  : system clock, synchronous active-high reset
//   ps2_clk/data    : raw asynchronous device lines
//   byte_valid_c    : accepted byte strobe (same cycle as the stop sample)
//   byte_c          : received byte, valid with byte_valid_c
//   err_c           : discarded frame strobe (bad stop, bad parity, timeout)
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 24000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid_c,
  output logic [7:0] byte_c,
  output logic       err_c
);

  localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  frame_state_e   state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           fall;
  logic           par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  // Clock filter, frame FSM and timeout.
  always_comb begin
    filt_d       = filt_q;
    filt_cnt_d   = '0;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_d        = tmo_q;
    byte_valid_c = 1'b0;
    err_c        = 1'b0;
    byte_c       = shift_q;
`ifdef PS2_PARITY_CHECK_EN
    par_d        = par_q;
`endif

    // Accept a new level only after FILT_LEN consecutive differing samples.
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end
    fall = filt_q && !filt_d;

    if (state_q == IDLE || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TCW'(1);
    end

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s2_q;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && par_ok) begin
            byte_valid_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TCW'(TIMEOUT - 1)) begin
      // Device stopped clocking mid-frame: abandon it.
      state_d   = IDLE;
      bit_cnt_d = '0;
      tmo_d     = '0;
      err_c     = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_assembler.sv
// ps2_key_assembler: collects PS/2 scan-code bytes into complete key
// sequences and publishes each one with an event toggle.
//   clk_sys, reset : system clock, synchronous active-high reset
//   bus.ps2_clk/data : raw device lines
//   bus.ps2_key    : [64] toggles per sequence, [63:0] bytes, last in [7:0]
//   bus.frame_err  : one-cycle pulse when a frame is discarded
// Build option: PS2_PARITY_CHECK_EN (passed down to ps2_frame_rx).
module ps2_key_assembler
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 24000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  ps2_key_assembler_if.slave   bus
);

  // Only the low 56 bits survive the next shift, so that is all we keep.
  localparam int unsigned SR_KEEP_W = PS2_SEQ_W - 8;

  logic       rx_valid_c, rx_err_c;
  logic [7:0] rx_byte_c;

  logic [SR_KEEP_W-1:0] sr_q, sr_d;
  logic [PS2_CNT_W-1:0] cnt_q, cnt_d;
  logic                 pause_q, pause_d;
  ps2_key_t             key_q, key_d;
  logic                 ferr_q, ferr_d;

  logic [PS2_SEQ_W-1:0] seq_new;
  logic [PS2_CNT_W-1:0] cnt_new;
  logic                 pause_new, prtsc_hold, done;

  ps2_frame_rx #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_rx (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_clk      (bus.ps2_clk),
    .ps2_data     (bus.ps2_data),
    .byte_valid_c (rx_valid_c),
    .byte_c       (rx_byte_c),
    .err_c        (rx_err_c)
  );

  // Output and sequence registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      pause_q <= 1'b0;
      key_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pause_q <= pause_d;
      key_q   <= key_d;
      ferr_q  <= ferr_d;
    end
  end

  // Sequence assembly and completion detection.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pause_d = pause_q;
    key_d   = key_q;
    ferr_d  = 1'b0;

    seq_new   = {sr_q, rx_byte_c};
    cnt_new   = (cnt_q == PS2_CNT_W'(PS2_PAUSE_LEN)) ? cnt_q : cnt_q + PS2_CNT_W'(1);
    pause_new = pause_q || ((cnt_q == '0) && (rx_byte_c == PS2_PFX_PAUSE));
    // Print-screen halves look like complete keys; hold them for the tail.
    prtsc_hold = ((cnt_new == PS2_CNT_W'(2)) && (seq_new[15:0] == 16'hE012)) ||
                 ((cnt_new == PS2_CNT_W'(3)) && (seq_new[23:0] == 24'hE0F07C));
    done = pause_new ? (cnt_new == PS2_CNT_W'(PS2_PAUSE_LEN))
                     : (!is_prefix(rx_byte_c) && !prtsc_hold);

    if (rx_err_c) begin
      ferr_d  = 1'b1;
      sr_d    = '0;
      cnt_d   = '0;
      pause_d = 1'b0;
    end else if (rx_valid_c) begin
      if (done) begin
        key_d.toggle = !key_q.toggle;
        key_d.seq    = seq_new;
        sr_d         = '0;
        cnt_d        = '0;
        pause_d      = 1'b0;
      end else begin
        sr_d    = seq_new[SR_KEEP_W-1:0];
        cnt_d   = cnt_new;
        pause_d = pause_new;
      end
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = ferr_q;

endmodule
